alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/alu_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-pass 32-bit ALU sequencer: op-codes,
// FSM state encoding and the high-pass op-code remap.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } seq_state_e;

    // Upper word of a wide add/subtract must chain the carry from the lower word.
    function automatic logic [3:0] hi_op(input logic [3:0] op);
        case (op)
            OP_ADD:  hi_op = OP_ADC;
            OP_SUB:  hi_op = OP_SBC;
            OP_RSB:  hi_op = OP_RSC;
            default: hi_op = op;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bus of the ALU sequencer; the slave modport is the sequencer side.
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_wide;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_n;
    logic        rsp_z;
    logic        rsp_c;
    logic        rsp_v;

    modport master (
        output req_valid, req_op, req_wide, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_n, rsp_z, rsp_c, rsp_v
    );

    modport slave (
        input  req_valid, req_op, req_wide, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_n, rsp_z, rsp_c, rsp_v
    );
endinterface

// File: rtl/alu_sequencer.sv
// Runs 32- or 64-bit operations through an external 32-bit ALU in one or two passes.
// Optional feature macro: ALU_SEQ_STICKY_C_EN (persistent carry feeds the low-pass carry-in).
import alu_pkg::*;

module alu_sequencer (
    input  logic              i_clk,
    input  logic              i_rst_n,
    alu_sequencer_if.slave    bus,
    output logic [31:0]       o_il,
    output logic [31:0]       o_ir,
    output logic [3:0]        o_if,
    output logic              o_cin,
    input  logic [31:0]       i_aluout,
    input  logic              i_cout,
    input  logic              i_v
);

    seq_state_e  r_state;
    logic [3:0]  r_op;
    logic        r_wide;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [31:0] r_il;
    logic [31:0] r_ir;
    logic [3:0]  r_if;
    logic        r_cin;
    logic [63:0] r_data;
    logic        r_n;
    logic        r_z;
    logic        r_c;
    logic        r_v;
    logic        r_rsp_valid;
    logic        w_lo_cin;
    logic        w_rsp_fire;

    assign w_rsp_fire = r_rsp_valid & bus.rsp_ready;

`ifdef ALU_SEQ_STICKY_C_EN
    logic r_sticky_c;

    // Carry persists across operations and is refreshed on every response hand-off.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sticky_c <= 1'b0;
        end else if (w_rsp_fire) begin
            r_sticky_c <= r_c;
        end else begin
            r_sticky_c <= r_sticky_c;
        end
    end

    assign w_lo_cin = r_sticky_c;
`else
    assign w_lo_cin = bus.req_cin;
`endif

    // Sequencer FSM; ALU drive signals are registered so they are valid for the whole pass.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= 4'd0;
            r_wide      <= 1'b0;
            r_a         <= 64'd0;
            r_b         <= 64'd0;
            r_il        <= 32'd0;
            r_ir        <= 32'd0;
            r_if        <= 4'd0;
            r_cin       <= 1'b0;
            r_data      <= 64'd0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.req_op;
                        r_wide  <= bus.req_wide;
                        r_a     <= bus.req_a;
                        r_b     <= bus.req_b;
                        r_il    <= bus.req_a[31:0];
                        r_ir    <= bus.req_b[31:0];
                        r_if    <= bus.req_op;
                        r_cin   <= w_lo_cin;
                        r_state <= ST_LO;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LO: begin
                    r_data <= {32'd0, i_aluout};
                    r_c    <= i_cout;
                    r_v    <= i_v;
                    if (r_wide) begin
                        r_il    <= r_a[63:32];
                        r_ir    <= r_b[63:32];
                        r_if    <= hi_op(r_op);
                        r_cin   <= i_cout;
                        r_state <= ST_HI;
                    end else begin
                        r_n         <= i_aluout[31];
                        r_z         <= (i_aluout == 32'd0);
                        r_il        <= 32'd0;
                        r_ir        <= 32'd0;
                        r_if        <= 4'd0;
                        r_cin       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_HI: begin
                    r_data[63:32] <= i_aluout;
                    r_n           <= i_aluout[31];
                    r_z           <= (i_aluout == 32'd0) && (r_data[31:0] == 32'd0);
                    r_c           <= i_cout;
                    r_v           <= i_v;
                    r_il          <= 32'd0;
                    r_ir          <= 32'd0;
                    r_if          <= 4'd0;
                    r_cin         <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is also gated by reset so it reads 0 throughout the reset pulse.
    assign bus.req_ready = (r_state == ST_IDLE) & i_rst_n;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_data;
    assign bus.rsp_n     = r_n;
    assign bus.rsp_z     = r_z;
    assign bus.rsp_c     = r_c;
    assign bus.rsp_v     = r_v;
    assign o_il          = r_il;
    assign o_ir          = r_ir;
    assign o_if          = r_if;
    assign o_cin         = r_cin;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 32-bit ALU attached to IL/IR/IF/CIN.
import alu_pkg::*;

module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] il, ir, aluout;
    logic [3:0]  alu_f;
    logic        cin, cout, v;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .bus      (bus),
        .o_il     (il),
        .o_ir     (ir),
        .o_if     (alu_f),
        .o_cin    (cin),
        .i_aluout (aluout),
        .i_cout   (cout),
        .i_v      (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder core returning {v, cout, sum}.
    function automatic logic [33:0] add3(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] s;
        logic        ov;
        s  = {1'b0, x} + {1'b0, y} + {32'd0, c};
        ov = (x[31] == y[31]) && (s[31] != x[31]);
        return {ov, s};
    endfunction

    // Reference ALU: ADD/ADC and SBC/RSC use carry-in, SUB/RSB/CMP force +1.
    function automatic logic [33:0] alu_model(input logic [3:0] f, input logic [31:0] x,
                                              input logic [31:0] y, input logic c);
        case (f)
            OP_AND, OP_TST:         return {2'b00, x & y};
            OP_EOR, OP_TEQ:         return {2'b00, x ^ y};
            OP_SUB, OP_CMP:         return add3(x, ~y, 1'b1);
            OP_RSB:                 return add3(y, ~x, 1'b1);
            OP_ADD, OP_ADC, OP_CMN: return add3(x, y, c);
            OP_SBC:                 return add3(x, ~y, c);
            OP_RSC:                 return add3(y, ~x, c);
            OP_ORR:                 return {2'b00, x | y};
            OP_MOV:                 return {2'b00, y};
            OP_BIC:                 return {2'b00, x & ~y};
            default:                return {2'b00, ~y};
        endcase
    endfunction

    always_comb begin
        {v, cout, aluout} = alu_model(alu_f, il, ir, cin);
    end

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;

    always @(posedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) n_xfer++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    logic [3:0]  p_if    [0:3];
    logic        p_cin   [0:3];
    logic [31:0] p_il    [0:3];
    logic        p_ready [0:3];

    // One complete operation: request, per-cycle sampling, optional stall, response hand-off.
    task automatic do_op(input logic [3:0] op, input logic wide, input logic [63:0] a,
                         input logic [63:0] b, input logic c, input int hold,
                         output logic [63:0] data, output logic [3:0] nzcv, output int lat);
        int guard;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before_op", {63'd0, bus.req_ready}, 64'd1);
        bus.req_op    = op;
        bus.req_wide  = wide;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = c;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat < 4) begin
                p_if[lat]    = alu_f;
                p_cin[lat]   = cin;
                p_il[lat]    = il;
                p_ready[lat] = bus.req_ready;
            end
        end while (bus.rsp_valid !== 1'b1 && lat < 10);
        data = bus.rsp_data;
        nzcv = {bus.rsp_n, bus.rsp_z, bus.rsp_c, bus.rsp_v};
        for (int k = 0; k < hold; k++) begin
            bus.req_valid = 1'b1;
            @(negedge clk);
            chk("stall_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("stall_rsp_data", bus.rsp_data, data);
            chk("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        wide;
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        logic [63:0] exp_data;
        logic [3:0]  exp_nzcv;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [0:10];
    logic [63:0] data, first_data;
    logic [3:0]  nzcv;
    int          lat;
    int          xfer_before;

    initial begin
        vecs[0]  = '{OP_ADD, 1'b0, 64'h0F, 64'h0F, 1'b0, 64'h1E, 4'b0000, 2};
        vecs[1]  = '{OP_ADD, 1'b1, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 4'b0000, 3};
        vecs[2]  = '{OP_SUB, 1'b0, 64'h5, 64'h5, 1'b0, 64'h0, 4'b0110, 2};
        vecs[3]  = '{OP_AND, 1'b0, 64'hF0F0, 64'hFF00, 1'b0, 64'hF000, 4'b0000, 2};
        vecs[4]  = '{OP_EOR, 1'b0, 64'hFFFFFFFF, 64'h0000FFFF, 1'b0, 64'hFFFF0000, 4'b1000, 2};
        vecs[5]  = '{OP_MVN, 1'b0, 64'h12345678_00000000, 64'hFFFFFFFF_00000000, 1'b0, 64'h00000000_FFFFFFFF, 4'b1000, 2};
        vecs[6]  = '{OP_ADD, 1'b0, 64'h7FFFFFFF, 64'h1, 1'b0, 64'h80000000, 4'b1001, 2};
        vecs[7]  = '{OP_SUB, 1'b1, 64'h00000001_00000000, 64'h1, 1'b0, 64'h00000000_FFFFFFFF, 4'b0010, 3};
        vecs[8]  = '{OP_MOV, 1'b1, 64'h0, 64'h80000000_00000000, 1'b0, 64'h80000000_00000000, 4'b1000, 3};
        vecs[9]  = '{OP_ORR, 1'b1, 64'h0, 64'h0, 1'b0, 64'h0, 4'b0100, 3};
`ifdef ALU_SEQ_STICKY_C_EN
        vecs[10] = '{OP_ADD, 1'b0, 64'h10, 64'h20, 1'b1, 64'h30, 4'b0000, 2};
`else
        vecs[10] = '{OP_ADD, 1'b0, 64'h10, 64'h20, 1'b1, 64'h31, 4'b0000, 2};
`endif

        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_wide  = 1'b0;
        bus.req_a     = 64'd0;
        bus.req_b     = 64'd0;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {63'd0, bus.req_ready}, 64'd0);
        chk("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("reset_rsp_data", bus.rsp_data, 64'd0);
        chk("reset_flags", {60'd0, bus.rsp_n, bus.rsp_z, bus.rsp_c, bus.rsp_v}, 64'd0);
        chk("reset_alu_drive", {27'd0, il, alu_f, cin, 1'b0} | {32'd0, ir}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {63'd0, bus.req_ready}, 64'd1);

        for (int i = 0; i <= 10; i++) begin
            do_op(vecs[i].op, vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].c, 0, data, nzcv, lat);
            chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            chk($sformatf("vec%0d_nzcv", i), {60'd0, nzcv}, {60'd0, vecs[i].exp_nzcv});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_lo_if", i), {60'd0, p_if[1]}, {60'd0, vecs[i].op});
            chk($sformatf("vec%0d_lo_il", i), {32'd0, p_il[1]}, {32'd0, vecs[i].a[31:0]});
            chk($sformatf("vec%0d_busy_ready", i), {63'd0, p_ready[1]}, 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_idle_drive", i), {27'd0, il, alu_f, cin, 1'b0} | {32'd0, ir}, 64'd0);
            chk($sformatf("vec%0d_idle_valid", i), {63'd0, bus.rsp_valid}, 64'd0);
        end

        // Wide add: high pass must run ADC with the low-pass carry.
        do_op(OP_ADD, 1'b1, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 0, data, nzcv, lat);
        chk("wide_hi_if", {60'd0, p_if[2]}, {60'd0, 4'b0101});
        chk("wide_hi_cin", {63'd0, p_cin[2]}, 64'd1);
        chk("wide_hi_il", {32'd0, p_il[2]}, 64'd0);
        chk("wide_data", data, 64'h00000001_00000000);
        chk("wide_latency", 64'(lat), 64'd3);

        // Response stalled for 5 cycles with a competing request pending.
        xfer_before = n_xfer;
        do_op(OP_ADD, 1'b0, 64'h1234, 64'h1111, 1'b0, 5, first_data, nzcv, lat);
        chk("stall_data", first_data, 64'h2345);
        @(negedge clk);
        chk("stall_one_transfer", 64'(n_xfer - xfer_before), 64'd1);

        // Reset pulse during the high pass of a wide op.
        xfer_before = n_xfer;
        bus.req_op    = OP_ADD;
        bus.req_wide  = 1'b1;
        bus.req_a     = 64'h00000000_FFFFFFFF;
        bus.req_b     = 64'h1;
        bus.req_cin   = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_hi_pass", {60'd0, alu_f}, {60'd0, 4'b0101});
        rst_n = 1'b0;
        #1;
        chk("abort_alu_drive", {27'd0, il, alu_f, cin, 1'b0} | {32'd0, ir}, 64'd0);
        chk("abort_req_ready_low", {63'd0, bus.req_ready}, 64'd0);
        chk("abort_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_after_release", {63'd0, bus.req_ready}, 64'd1);
        bus.rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("abort_no_response", 64'(n_xfer - xfer_before), 64'd0);

        // Carry from a previous response is reused only in the sticky build.
        do_op(OP_ADD, 1'b0, 64'hFFFFFFFF, 64'h1, 1'b0, 0, data, nzcv, lat);
        chk("carry_gen_data", data, 64'd0);
        chk("carry_gen_nzcv", {60'd0, nzcv}, {60'd0, 4'b0110});
        do_op(OP_ADD, 1'b0, 64'h0, 64'h0, 1'b0, 0, data, nzcv, lat);
`ifdef ALU_SEQ_STICKY_C_EN
        chk("carry_reuse_data", data, 64'd1);
`else
        chk("carry_reuse_data", data, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
